// File: rtl/crc32_stream_engine.sv
// rtl/crc32_stream_engine.sv - multi-byte-per-beat CRC-32 engine for framed streams with result handshake
// Optional macro CRC32_ERRCNT_EN adds a saturating bad-frame counter on err_cnt.
module crc32_stream_engine #(
    parameter int          DATA_BYTES = 4,
    parameter logic [31:0] POLY       = 32'h04C11DB7,
    parameter logic [31:0] INIT       = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT     = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE    = 32'hC704DD7B
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [8*DATA_BYTES-1:0]         in_data,
    input  logic                            in_sof,
    input  logic                            in_eof,
    input  logic [$clog2(DATA_BYTES):0]     in_bytes,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [31:0]                     res_crc,
    output logic                            res_ok,
    output logic                            ev_drop,
    output logic                            ev_abort
`ifdef CRC32_ERRCNT_EN
    ,
    output logic [15:0]                     err_cnt
`endif
);

    localparam int BW = $clog2(DATA_BYTES) + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   crc_q, crc_d;
    logic          res_valid_q, res_valid_d;
    logic [31:0]   res_crc_q, res_crc_d;
    logic          res_ok_q, res_ok_d;
    logic          ev_drop_q, ev_drop_d;
    logic          ev_abort_q, ev_abort_d;
`ifdef CRC32_ERRCNT_EN
    logic [15:0]   err_cnt_q, err_cnt_d;
`endif

    logic          accept;
    logic [BW-1:0] lanes;
    logic [31:0]   seed;
    logic [31:0]   crc_beat;

    // MSB-first byte step, no reflection.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {b, 24'h0};
        for (int k = 0; k < 8; k++) begin
            r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        end
        return r;
    endfunction

    assign in_ready = !res_valid_q || res_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        lanes = BW'(DATA_BYTES);
        if (in_eof && (in_bytes != '0) && (in_bytes <= BW'(DATA_BYTES))) begin
            lanes = in_bytes;
        end
        seed     = in_sof ? INIT : crc_q;
        crc_beat = seed;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (i < int'(lanes)) begin
                crc_beat = crc_byte(crc_beat, in_data[8*i +: 8]);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        res_valid_d = res_valid_q && !res_ready;
        res_crc_d   = res_crc_q;
        res_ok_d    = res_ok_q;
        ev_drop_d   = 1'b0;
        ev_abort_d  = 1'b0;
`ifdef CRC32_ERRCNT_EN
        err_cnt_d   = err_cnt_q;
`endif
        if (accept) begin
            if (in_sof || (state_q == FRAME)) begin
                ev_abort_d = in_sof && (state_q == FRAME);
                crc_d      = crc_beat;
                if (in_eof) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b1;
                    res_crc_d   = crc_beat ^ XOROUT;
                    res_ok_d    = (crc_beat == RESIDUE);
`ifdef CRC32_ERRCNT_EN
                    if ((crc_beat != RESIDUE) && (err_cnt_q != 16'hFFFF)) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
`endif
                end else begin
                    state_d = FRAME;
                end
            end else begin
                // Beat outside any frame: dropped, register untouched.
                ev_drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            res_valid_q <= 1'b0;
            res_crc_q   <= 32'h0;
            res_ok_q    <= 1'b0;
            ev_drop_q   <= 1'b0;
            ev_abort_q  <= 1'b0;
`ifdef CRC32_ERRCNT_EN
            err_cnt_q   <= 16'h0;
`endif
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            res_valid_q <= res_valid_d;
            res_crc_q   <= res_crc_d;
            res_ok_q    <= res_ok_d;
            ev_drop_q   <= ev_drop_d;
            ev_abort_q  <= ev_abort_d;
`ifdef CRC32_ERRCNT_EN
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_crc   = res_crc_q;
    assign res_ok    = res_ok_q;
    assign ev_drop   = ev_drop_q;
    assign ev_abort  = ev_abort_q;
`ifdef CRC32_ERRCNT_EN
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: doc/crc32_stream_engine.md
# crc32_stream_engine

Parametrised, multi-byte-per-beat CRC-32 engine for framed streams. It is the next generation of the team's byte-wide 802.3 CRC generator. It accepts up to DATA_BYTES bytes per clock under a valid/ready handshake with start/end-of-frame marking and partial last beats. At end of frame it presents a result (final CRC plus residue check) through its own valid/ready handshake. It sits between the MAC byte-lane packer and the frame status logic.

## Interface
- DATA_BYTES, 4: bytes per input beat, legal 1..8.
- POLY, 32'h04C11DB7: generator polynomial, normal (MSB-first) form.
- INIT, 32'hFFFFFFFF: CRC register value at each start of frame.
- XOROUT, 32'hFFFFFFFF: XOR applied to the register to form res_crc.
- RESIDUE, 32'hC704DD7B: register value that indicates a good frame when the frame includes its appended CRC.
- clk  in  1  clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine accepts a beat this cycle.
- in_data  in  8*DATA_BYTES  payload; lane 0 = in_data[7:0] is processed first.
- in_sof  in  1  beat is the first of a frame.
- in_eof  in  1  beat is the last of a frame.
- in_bytes  in  $clog2(DATA_BYTES)+1  count of valid lanes on an eof beat (lanes 0..in_bytes-1).
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_crc  out  32  final CRC, equal to register ^ XOROUT.
- res_ok  out  1  register == RESIDUE.
- ev_drop  out  1  one-cycle pulse: a beat was accepted outside a frame and discarded.
- ev_abort  out  1  one-cycle pulse: a frame was restarted by sof before its eof.

## Operation
- Beat accepted when in_valid && in_ready. in_ready = !res_valid || res_ready.
- FSM states:
  - IDLE: waiting for a frame.
  - FRAME: frame in progress.
- Reset puts the FSM in IDLE, crc_reg = INIT, and all outputs to 0 except in_ready = 1.
- Accepted sof beat, from either state:
  - Seed from INIT, process the beat, go to FRAME.
  - If the state was FRAME, also pulse ev_abort; no result is produced for the aborted frame.
- Accepted non-sof beat in FRAME: process it from crc_reg.
- Accepted non-sof beat in IDLE: discard it, pulse ev_drop, crc_reg unchanged.
- Accepted eof beat:
  - Process only lanes 0..in_bytes-1. in_bytes = 0 or in_bytes > DATA_BYTES is treated as DATA_BYTES.
  - Load res_crc and res_ok from the post-beat register, set res_valid, return to IDLE.
- in_bytes is ignored on non-eof beats; all lanes are valid.
- A beat with sof and eof together is a complete one-beat frame.
- Per-lane update is the standard byte-step, MSB-first within a byte: x = reg[31:24] ^ byte, then 8 shift/XOR steps by POLY. The steps are unrolled combinationally DATA_BYTES deep; there is no reflection.
- res_crc, res_ok and res_valid hold until res_valid && res_ready. A new eof accepted in the same cycle overwrites the result (back-to-back results, zero bubble).
- in_valid is ignored while in_ready = 0.

## Timing
- Throughput: one beat per cycle, with no gap between frames.
- Latency: res_valid rises on the clock edge that accepts the eof beat, i.e. it is visible the next cycle.
- in_ready depends combinationally on res_ready; there is no other input-to-output combinational path.
- ev_drop and ev_abort are registered, high for the cycle after the offending beat is accepted.
- Reset asserted mid-frame or mid-result: in IDLE and res_valid = 0 immediately (asynchronous). Restart on the first edge after release.

## Configuration
- CRC32_ERRCNT_EN defined:
  - Adds output err_cnt[15:0], reset 0.
  - Increments on each result produced with res_ok = 0.
  - Saturates at 16'hFFFF.
- CRC32_ERRCNT_EN undefined: no err_cnt port and no counter logic; all other behaviour is identical.

## Test plan
- Default parameters, ASCII "123456789" in beats "1234" (sof), "5678", "9" (eof, in_bytes = 1) -> res_valid one cycle later, res_crc = 32'hFC891918, res_ok = 0.
- Same frame with bytes FC 89 19 18 appended (last beat "9",FC,89,19, then 18 with eof, in_bytes = 1) -> res_ok = 1, register = 32'hC704DD7B.
- DATA_BYTES = 1, the same 9 bytes one per beat -> res_crc = 32'hFC891918. Two frames back to back with res_ready = 1 -> in_ready stays 1, two results on consecutive frame ends.
- Hold res_ready = 0 after an eof -> in_ready = 0 and result held stable. Assert res_ready -> in_ready = 1 in the same cycle.
- Sequences:
  - Data beat with no sof while IDLE -> ev_drop pulse, no result.
  - sof mid-frame -> ev_abort pulse, result covers only the new frame.
  - sof+eof single beat -> result produced.
- Assert reset mid-frame -> res_valid = 0, in_ready = 1. With CRC32_ERRCNT_EN, after reset release send 3 bad frames -> err_cnt = 3 (reset clears it to 0).
